pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic Y86 inter-stage pipeline register (F/D, D/E, E/M, M/W) with stall, bubble and valid tracking.
//  Widths and the number of value/destination fields are parameters, so one module covers every stage boundary.
//  Adds an asynchronous reset to the bubble state, a stall watchdog and a sticky control-error flag.
//  Sits between two pipeline stages and is driven by the hazard/control unit.
// PARAMETERS
//  STAT_W      3      width of status field
//  ICODE_W     4      width of icode field
//  VAL_W       64     width of each value field (valE, valM, valA, ...)
//  NVAL        2      number of value fields carried
//  REG_W       4      width of each register-ID field
//  NDST        2      number of register-ID fields carried (dstE, dstM, ...)
//  BUB_STAT    3'd1   status loaded on bubble/reset (SAOK)
//  BUB_ICODE   4'h1   icode loaded on bubble/reset (INOP)
//  RNONE       4'hF   register ID loaded on bubble/reset
//  STALL_LIMIT 16     consecutive stall cycles before stall_long asserts (1..65535)
// PORTS
//  clk         in   1             rising-edge clock
//  rst         in   1             asynchronous, active-high reset
//  stall       in   1             hold current contents
//  bubble      in   1             load NOP bubble
//  in_valid    in   1             upstream slot carries a real instruction
//  in_stat     in   STAT_W        upstream status
//  in_icode    in   ICODE_W       upstream icode
//  in_val      in   NVAL*VAL_W    packed value fields, field k = [k*VAL_W +: VAL_W]
//  in_dst      in   NDST*REG_W    packed register IDs, field k = [k*REG_W +: REG_W]
//  out_valid   out  1             registered valid
//  out_stat    out  STAT_W        registered status
//  out_icode   out  ICODE_W       registered icode
//  out_val     out  NVAL*VAL_W    registered values
//  out_dst     out  NDST*REG_W    registered register IDs
//  stall_long  out  1             stall held for >= STALL_LIMIT consecutive cycles
//  ctl_err     out  1             sticky: stall and bubble sampled high together
// BEHAVIOUR
//  - Reset (asynchronous, active-high): out_valid=0, out_stat=BUB_STAT, out_icode=BUB_ICODE, out_val=0,
//    every out_dst field=RNONE, stall_long=0, ctl_err=0, stall counter=0. The values apply as soon as rst asserts, including mid-stall.
//  - Each rising clk edge with rst low, evaluated in priority order:
//    1. stall=1: all out_* hold. Applies even when bubble=1 (stall wins). Set ctl_err if bubble=1.
//    2. bubble=1: load the bubble state (same values as reset). out_valid=0.
//    3. otherwise: load all in_* fields. out_valid=in_valid.
//  - Latency: 1 cycle from in_* to out_*. There is no combinational path from in to out.
//  - Stall counter (16 bit): increments on each edge with stall=1 and saturates at 65535. Clears to 0 on any edge with stall=0.
//  - stall_long is registered and equals (counter_next >= STALL_LIMIT). It therefore rises on the STALL_LIMIT-th consecutive stalled edge and falls on the first unstalled edge.
//  - ctl_err is sticky and is cleared only by rst.
//  - Field packing is the same for inputs and outputs. Field 0 is in the LSBs.
// CONFIGURATION
//  PIPE_STAGE_PERF_EN defined: adds outputs perf_stall_cnt[31:0] and perf_bubble_cnt[31:0].
//    - They count edges where rule 1 or rule 2 applied.
//    - Both saturate at 32'hFFFF_FFFF and reset to 0 on rst.
//    - A stall+bubble edge counts as a stall only.
//  PIPE_STAGE_PERF_EN undefined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
//  1. Assert rst mid-cycle with outputs loaded -> outputs go to the bubble state immediately, without a clk edge: icode=4'h1, dst=4'hF/4'hF, valid=0.
//  2. Load in_icode=4'h6, in_val={64'h5,64'hA}, in_dst={4'h3,4'hF}, in_valid=1 -> the values appear on out_* after exactly 1 edge, with out_valid=1.
//  3. Load as in test 2, then assert stall=1 for 3 edges while the inputs change -> the outputs hold 4'h6/64'hA. After release the next edge loads the new inputs.
//  4. Assert bubble=1 with in_icode=4'h2 -> next edge gives out_icode=4'h1, out_dst=4'hF/4'hF, out_valid=0, out_val=0.
//  5. Assert stall=1 and bubble=1 on the same edge -> outputs hold and ctl_err=1. ctl_err stays 1 after both drop and clears only on rst.
//  6. STALL_LIMIT=4, hold stall for 6 edges -> stall_long is 0 through edge 3, 1 from edge 4, and 0 on the first edge with stall=0.
//     With PIPE_STAGE_PERF_EN defined -> perf_stall_cnt=6.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Upstream/downstream bundle for one Y86 inter-stage register.
//               Perf counter signals exist only with PIPE_STAGE_PERF_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pipe_stage_reg_if #(
    parameter int STAT_W  = 3,
    parameter int ICODE_W = 4,
    parameter int VAL_W   = 64,
    parameter int NVAL    = 2,
    parameter int REG_W   = 4,
    parameter int NDST    = 2
);
    logic                    stall;
    logic                    bubble;
    logic                    in_valid;
    logic [STAT_W-1:0]       in_stat;
    logic [ICODE_W-1:0]      in_icode;
    logic [NVAL*VAL_W-1:0]   in_val;
    logic [NDST*REG_W-1:0]   in_dst;
    logic                    out_valid;
    logic [STAT_W-1:0]       out_stat;
    logic [ICODE_W-1:0]      out_icode;
    logic [NVAL*VAL_W-1:0]   out_val;
    logic [NDST*REG_W-1:0]   out_dst;
    logic                    stall_long;
    logic                    ctl_err;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]             perf_stall_cnt;
    logic [31:0]             perf_bubble_cnt;
`endif

    modport master (
        output stall, bubble, in_valid, in_stat, in_icode, in_val, in_dst,
`ifdef PIPE_STAGE_PERF_EN
        input  perf_stall_cnt, perf_bubble_cnt,
`endif
        input  out_valid, out_stat, out_icode, out_val, out_dst, stall_long, ctl_err
    );

    modport slave (
        input  stall, bubble, in_valid, in_stat, in_icode, in_val, in_dst,
`ifdef PIPE_STAGE_PERF_EN
        output perf_stall_cnt, perf_bubble_cnt,
`endif
        output out_valid, out_stat, out_icode, out_val, out_dst, stall_long, ctl_err
    );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic Y86 pipeline register with stall/bubble, stall
//               watchdog and sticky control-error flag. Optional perf
//               counters are enabled by defining PIPE_STAGE_PERF_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int                  STAT_W      = 3,
    parameter int                  ICODE_W     = 4,
    parameter int                  VAL_W       = 64,
    parameter int                  NVAL        = 2,
    parameter int                  REG_W       = 4,
    parameter int                  NDST        = 2,
    parameter logic [STAT_W-1:0]   BUB_STAT    = 3'd1,
    parameter logic [ICODE_W-1:0]  BUB_ICODE   = 4'h1,
    parameter logic [REG_W-1:0]    RNONE       = 4'hF,
    parameter int                  STALL_LIMIT = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pipe_stage_reg_if.slave    bus
);

    localparam logic [NDST*REG_W-1:0] C_BUB_DST   = {NDST{RNONE}};
    localparam logic [15:0]           C_LIMIT     = 16'(STALL_LIMIT);
    localparam logic [15:0]           C_CNT_MAX   = 16'hFFFF;

    logic                    valid_q,      valid_d;
    logic [STAT_W-1:0]       stat_q,       stat_d;
    logic [ICODE_W-1:0]      icode_q,      icode_d;
    logic [NVAL*VAL_W-1:0]   val_q,        val_d;
    logic [NDST*REG_W-1:0]   dst_q,        dst_d;
    logic [15:0]             stall_cnt_q,  stall_cnt_d;
    logic                    stall_long_q, stall_long_d;
    logic                    ctl_err_q,    ctl_err_d;

    // Stall has priority over bubble; the pair together is a control fault.
    always_comb begin
        valid_d      = valid_q;
        stat_d       = stat_q;
        icode_d      = icode_q;
        val_d        = val_q;
        dst_d        = dst_q;
        ctl_err_d    = ctl_err_q | (bus.stall & bus.bubble);
        stall_cnt_d  = 16'd0;
        if (bus.stall) begin
            stall_cnt_d = (stall_cnt_q == C_CNT_MAX) ? C_CNT_MAX : stall_cnt_q + 16'd1;
        end else if (bus.bubble) begin
            valid_d = 1'b0;
            stat_d  = BUB_STAT;
            icode_d = BUB_ICODE;
            val_d   = '0;
            dst_d   = C_BUB_DST;
        end else begin
            valid_d = bus.in_valid;
            stat_d  = bus.in_stat;
            icode_d = bus.in_icode;
            val_d   = bus.in_val;
            dst_d   = bus.in_dst;
        end
        stall_long_d = (stall_cnt_d >= C_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            stat_q       <= BUB_STAT;
            icode_q      <= BUB_ICODE;
            val_q        <= '0;
            dst_q        <= C_BUB_DST;
            stall_cnt_q  <= 16'd0;
            stall_long_q <= 1'b0;
            ctl_err_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            stat_q       <= stat_d;
            icode_q      <= icode_d;
            val_q        <= val_d;
            dst_q        <= dst_d;
            stall_cnt_q  <= stall_cnt_d;
            stall_long_q <= stall_long_d;
            ctl_err_q    <= ctl_err_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_stat   = stat_q;
    assign bus.out_icode  = icode_q;
    assign bus.out_val    = val_q;
    assign bus.out_dst    = dst_q;
    assign bus.stall_long = stall_long_q;
    assign bus.ctl_err    = ctl_err_q;

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [31:0] C_PERF_MAX = 32'hFFFF_FFFF;

    logic [31:0] perf_stall_q,  perf_stall_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    // A stall+bubble edge is attributed to the stall counter only.
    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_bubble_d = perf_bubble_q;
        if (bus.stall) begin
            if (perf_stall_q != C_PERF_MAX) perf_stall_d = perf_stall_q + 32'd1;
        end else if (bus.bubble) begin
            if (perf_bubble_q != C_PERF_MAX) perf_bubble_d = perf_bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q  <= 32'd0;
            perf_bubble_q <= 32'd0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign bus.perf_stall_cnt  = perf_stall_q;
    assign bus.perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed + random bench for pipe_stage_reg against a
//               rule-level reference model. Honours PIPE_STAGE_PERF_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;
    localparam int STAT_W = 3, ICODE_W = 4, VAL_W = 64, NVAL = 2, REG_W = 4, NDST = 2;
    localparam int LIMIT  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    pipe_stage_reg_if #(.STAT_W(STAT_W), .ICODE_W(ICODE_W), .VAL_W(VAL_W),
                        .NVAL(NVAL), .REG_W(REG_W), .NDST(NDST)) bus ();

    pipe_stage_reg #(.STAT_W(STAT_W), .ICODE_W(ICODE_W), .VAL_W(VAL_W), .NVAL(NVAL),
                     .REG_W(REG_W), .NDST(NDST), .BUB_STAT(3'd1), .BUB_ICODE(4'h1),
                     .RNONE(4'hF), .STALL_LIMIT(LIMIT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic         m_valid;
    logic [2:0]   m_stat;
    logic [3:0]   m_icode;
    logic [127:0] m_val;
    logic [7:0]   m_dst;
    int           m_run;
    logic         m_err;
    longint       m_pstall, m_pbub;

    function automatic void model_reset();
        m_valid = 0; m_stat = 3'd1; m_icode = 4'h1; m_val = '0; m_dst = 8'hFF;
        m_run = 0; m_err = 0; m_pstall = 0; m_pbub = 0;
    endfunction

    function automatic void model_edge(logic st, logic bb, logic iv, logic [2:0] is,
                                       logic [3:0] ic, logic [127:0] vl, logic [7:0] ds);
        if (st) begin
            m_run = (m_run < 65535) ? m_run + 1 : 65535;
            if (bb) m_err = 1;
            m_pstall++;
        end else begin
            m_run = 0;
            if (bb) begin
                m_valid = 0; m_stat = 3'd1; m_icode = 4'h1; m_val = '0; m_dst = 8'hFF;
                m_pbub++;
            end else begin
                m_valid = iv; m_stat = is; m_icode = ic; m_val = vl; m_dst = ds;
            end
        end
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".valid"}, 128'(bus.out_valid), 128'(m_valid));
        chk({tag, ".stat"},  128'(bus.out_stat),  128'(m_stat));
        chk({tag, ".icode"}, 128'(bus.out_icode), 128'(m_icode));
        chk({tag, ".val"},   bus.out_val,         m_val);
        chk({tag, ".dst"},   128'(bus.out_dst),   128'(m_dst));
        chk({tag, ".slong"}, 128'(bus.stall_long), 128'(m_run >= LIMIT));
        chk({tag, ".err"},   128'(bus.ctl_err),   128'(m_err));
`ifdef PIPE_STAGE_PERF_EN
        chk({tag, ".pstall"}, 128'(bus.perf_stall_cnt),  128'(m_pstall));
        chk({tag, ".pbub"},   128'(bus.perf_bubble_cnt), 128'(m_pbub));
`endif
    endtask

    // One rising edge: advance the model with the inputs seen at the edge, then check.
    task automatic tick(string tag);
        @(posedge clk);
        model_edge(bus.stall, bus.bubble, bus.in_valid, bus.in_stat,
                   bus.in_icode, bus.in_val, bus.in_dst);
        #1;
        check_all(tag);
    endtask

    task automatic drive(logic st, logic bb, logic iv, logic [2:0] is,
                         logic [3:0] ic, logic [127:0] vl, logic [7:0] ds);
        bus.stall = st; bus.bubble = bb; bus.in_valid = iv; bus.in_stat = is;
        bus.in_icode = ic; bus.in_val = vl; bus.in_dst = ds;
    endtask

    task automatic drive_random(int p_stall, int p_bub);
        drive(($urandom_range(99) < p_stall), ($urandom_range(99) < p_bub),
              1'($urandom), 3'($urandom), 4'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, 8'($urandom));
    endtask

    // Mid-cycle asynchronous reset: outputs must change with no clock edge.
    task automatic async_reset(string tag);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all(tag);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, '0, '0, '0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) rst = 1'b0;

        // Plain load, one-edge latency
        drive(0, 0, 1, 3'd1, 4'h6, {64'h5, 64'hA}, {4'h3, 4'hF});
        tick("load");
        chk("load.icode_dir", 128'(bus.out_icode), 128'(4'h6));
        chk("load.val0_dir",  128'(bus.out_val[63:0]), 128'(64'hA));

        // Stall three edges while inputs change
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 3'd2, 4'(k + 2), {64'(k), 64'(k + 100)}, 8'h21);
            tick("stall");
            chk("stall.hold_icode", 128'(bus.out_icode), 128'(4'h6));
            chk("stall.hold_val0",  128'(bus.out_val[63:0]), 128'(64'hA));
        end
        drive(0, 0, 1, 3'd4, 4'h7, {64'h77, 64'h88}, 8'h45);
        tick("release");
        chk("release.icode_dir", 128'(bus.out_icode), 128'(4'h7));

        // Bubble
        drive(0, 1, 1, 3'd1, 4'h2, {64'h1, 64'h2}, 8'h12);
        tick("bubble");
        chk("bubble.icode_dir", 128'(bus.out_icode), 128'(4'h1));
        chk("bubble.dst_dir",   128'(bus.out_dst),   128'(8'hFF));

        // Async reset with loaded outputs
        drive(0, 0, 1, 3'd3, 4'h6, {64'h5, 64'hA}, 8'h3F);
        tick("preload");
        async_reset("async_rst");
        chk("async_rst.icode_dir", 128'(bus.out_icode), 128'(4'h1));

        // Watchdog: six stalled edges after reset, then release
        for (int k = 1; k <= 6; k++) begin
            drive_random(100, 0);
            tick("wdog");
            chk("wdog.slong_dir", 128'(bus.stall_long), 128'(k >= LIMIT));
        end
`ifdef PIPE_STAGE_PERF_EN
        chk("wdog.perf6_dir", 128'(bus.perf_stall_cnt), 128'(32'd6));
`endif
        drive_random(0, 0);
        tick("wdog_rel");
        chk("wdog_rel.slong_dir", 128'(bus.stall_long), 128'(1'b0));

        // Stall + bubble together: hold and sticky error
        drive_random(100, 100);
        tick("both");
        chk("both.err_dir", 128'(bus.ctl_err), 128'(1'b1));
        for (int k = 0; k < 3; k++) begin
            drive_random(0, 30);
            tick("sticky");
            chk("sticky.err_dir", 128'(bus.ctl_err), 128'(1'b1));
        end
        async_reset("err_clr");
        chk("err_clr.err_dir", 128'(bus.ctl_err), 128'(1'b0));

        // Random traffic with occasional long stalls and resets
        for (int n = 0; n < 400; n++) begin
            if ((n % 100) > 80) drive_random(100, 30);
            else                drive_random(25, 20);
            tick("rand");
            if ($urandom_range(99) < 2) async_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
